// File: rtl/ir_bridge_pkg.sv
// Shared FSM encoding, ASCII constants and frame length for the IR command UART bridge.
// Frame terminator is selected by IR_BRIDGE_CRLF_EN (CR LF when defined, single space otherwise).
package ir_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

`ifdef IR_BRIDGE_CRLF_EN
   localparam int unsigned FRAME_LEN = 4;
`else
   localparam int unsigned FRAME_LEN = 3;
`endif

   function automatic logic [7:0] nib2hex(input logic [3:0] nib);
      if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
      else             return ASCII_A + {4'h0, nib - 4'd10};
   endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Synchronous byte FIFO with registered occupancy level and full/empty flags.
// Push is refused when full, judged on the level before any same-cycle pop.
module ir_cmd_fifo
   import ir_bridge_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/ir_cmd_uart_bridge.sv
// Buffers decoded IR command bytes and sends each to a UART as ASCII hex plus terminator.
// Define IR_BRIDGE_CRLF_EN for a CR LF terminator; default is a single space.
module ir_cmd_uart_bridge
   import ir_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk_50,
   input  logic                          reset,
   input  logic [7:0]                    ir_cmd,
   input  logic                          ir_cmd_ready,
   input  logic                          tx_ready,
   output logic [7:0]                    tx_data,
   output logic                          tx_load,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [7:0]                    drop_count,
   output logic                          busy
);

   localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_load_q, tx_load_d;
   logic       overflow_q, overflow_d;
   logic [7:0] drop_count_q, drop_count_d;
   logic       fifo_pop, fifo_full, fifo_empty, drop;
   logic [7:0] fifo_dout;

   ir_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_50),
      .rst_n (reset),
      .push  (ir_cmd_ready),
      .din   (ir_cmd),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   function automatic logic [7:0] frame_char(input logic [7:0] cmd, input logic [1:0] idx);
      case (idx)
         2'd0:    return nib2hex(cmd[7:4]);
         2'd1:    return nib2hex(cmd[3:0]);
`ifdef IR_BRIDGE_CRLF_EN
         2'd2:    return ASCII_CR;
         default: return ASCII_LF;
`else
         default: return ASCII_SPACE;
`endif
      endcase
   endfunction

   assign drop = ir_cmd_ready && fifo_full;

   always_comb begin
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;
      if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
   end

   // tx_load and tx_data are registered, so the strobe lands in the GAP cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cmd_d     = cmd_q;
      tx_data_d = tx_data_q;
      tx_load_d = 1'b0;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty) state_d = POP;
         POP: begin
            cmd_d    = fifo_dout;
            fifo_pop = 1'b1;
            idx_d    = 2'd0;
            state_d  = SEND;
         end
         SEND: if (tx_ready) begin
            tx_data_d = frame_char(cmd_q, idx_q);
            tx_load_d = 1'b1;
            state_d   = GAP;
         end
         GAP: begin
            if (idx_q == LAST_IDX) state_d = IDLE;
            else begin
               idx_d   = idx_q + 2'd1;
               state_d = SEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         tx_data_q    <= 8'h00;
         tx_load_q    <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         tx_data_q    <= tx_data_d;
         tx_load_q    <= tx_load_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge clk_50) begin
      cmd_q <= cmd_d;
   end

   assign tx_data    = tx_data_q;
   assign tx_load    = tx_load_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ir_cmd_uart_bridge.sv
// Directed self-checking bench for ir_cmd_uart_bridge (honours IR_BRIDGE_CRLF_EN for terminators).
module tb_ir_cmd_uart_bridge;

   localparam int FIFO_DEPTH = 8;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef IR_BRIDGE_CRLF_EN
   localparam int FLEN = 4;
   localparam logic [7:0] T0 = 8'h0D;
`else
   localparam int FLEN = 3;
   localparam logic [7:0] T0 = 8'h20;
`endif
   localparam logic [7:0] T1 = 8'h0A;

   logic          clk_50 = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    ir_cmd = 8'h00;
   logic          ir_cmd_ready = 1'b0;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_load;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic [7:0]    drop_count;
   logic          busy;

   int n_checks = 0;
   int n_pass = 0;
   logic [7:0] captured[$];
   int dbl_load = 0;
   int load_nobusy = 0;
   logic prev_load = 1'b0;

   ir_cmd_uart_bridge #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_50(clk_50), .reset(reset), .ir_cmd(ir_cmd), .ir_cmd_ready(ir_cmd_ready),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_load(tx_load), .fifo_level(fifo_level),
      .overflow(overflow), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk_50 = ~clk_50;

   always @(posedge clk_50) begin
      #1;
      if (tx_load) begin
         captured.push_back(tx_data);
         if (prev_load) dbl_load++;
         if (!busy) load_nobusy++;
      end
      prev_load = tx_load;
   end

   function automatic logic [7:0] exp_char(input logic [7:0] c, input int k);
      logic [3:0] n;
      if (k == 2) return T0;
      if (k == 3) return T1;
      n = (k == 0) ? c[7:4] : c[3:0];
      return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
   endfunction

   task automatic strobe(input logic [7:0] b);
      @(negedge clk_50);
      ir_cmd = b;
      ir_cmd_ready = 1'b1;
      @(negedge clk_50);
      ir_cmd_ready = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk_50);
         #2;
         if (captured.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk_50);
         if (!busy && fifo_level == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_50);
      reset = 1'b0;
      ir_cmd_ready = 1'b0;
      tx_ready = 1'b0;
      repeat (2) @(negedge clk_50);
      reset = 1'b1;
      @(negedge clk_50);
      captured.delete();
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (tx_load !== 1'b0) $display("FAIL reset_tx_load: got %b want 0", tx_load); else n_pass++;
      n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 8'h00) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else n_pass++;
      @(negedge clk_50);
      reset = 1'b1;
      @(negedge clk_50);
   endtask

   task automatic test_single();
      logic [7:0] exp [4];
      bit ok;
      exp = '{8'h35, 8'h41, T0, T1};
      captured.delete();
      tx_ready = 1'b1;
      strobe(8'h5A);
      @(negedge clk_50);
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_start: got %b want 1", busy); else n_pass++;
      wait_bytes(FLEN, 80, ok);
      n_checks++; if (!ok) $display("FAIL single_timeout: got %0d bytes want %0d", captured.size(), FLEN); else n_pass++;
      for (int k = 0; k < FLEN; k++) begin
         n_checks++;
         if (captured.size() <= k || captured[k] !== exp[k])
            $display("FAIL single_char%0d: got %h want %h", k, (captured.size() > k) ? captured[k] : 8'hxx, exp[k]);
         else n_pass++;
      end
      wait_idle(20, ok);
      n_checks++; if (!ok) $display("FAIL single_idle: busy %b level %0d want 0/0", busy, fifo_level); else n_pass++;
      n_checks++; if (tx_data !== exp[FLEN-1]) $display("FAIL single_hold: got %h want %h", tx_data, exp[FLEN-1]); else n_pass++;
   endtask

   task automatic test_nibble_edges();
      logic [7:0] exp[$];
      bit ok;
      exp.push_back(8'h30); exp.push_back(8'h39); exp.push_back(T0);
`ifdef IR_BRIDGE_CRLF_EN
      exp.push_back(T1);
`endif
      exp.push_back(8'h46); exp.push_back(8'h30); exp.push_back(T0);
`ifdef IR_BRIDGE_CRLF_EN
      exp.push_back(T1);
`endif
      captured.delete();
      tx_ready = 1'b1;
      strobe(8'h09);
      strobe(8'hF0);
      wait_bytes(2 * FLEN, 120, ok);
      n_checks++; if (!ok) $display("FAIL nibble_timeout: got %0d bytes want %0d", captured.size(), 2 * FLEN); else n_pass++;
      for (int k = 0; k < 2 * FLEN; k++) begin
         n_checks++;
         if (captured.size() <= k || captured[k] !== exp[k])
            $display("FAIL nibble_char%0d: got %h want %h", k, (captured.size() > k) ? captured[k] : 8'hxx, exp[k]);
         else n_pass++;
      end
      wait_idle(20, ok);
   endtask

   task automatic test_backpressure();
      int stray, changed, c;
      bit ok;
      captured.delete();
      tx_ready = 1'b1;
      strobe(8'h3C);
      for (c = 0; c < 20; c++) begin
         if (tx_load) break;
         @(negedge clk_50);
      end
      n_checks++; if (c >= 20) $display("FAIL bp_first_load: got none want tx_load within 20 cycles"); else n_pass++;
      tx_ready = 1'b0;
      n_checks++; if (tx_data !== 8'h33) $display("FAIL bp_first_char: got %h want 33", tx_data); else n_pass++;
      stray = 0;
      changed = 0;
      repeat (20) begin
         @(negedge clk_50);
         if (tx_load) stray++;
         if (tx_data !== 8'h33) changed++;
      end
      n_checks++; if (stray != 0) $display("FAIL bp_no_load: got %0d loads want 0", stray); else n_pass++;
      n_checks++; if (changed != 0) $display("FAIL bp_data_held: got %0d changes want 0", changed); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
      tx_ready = 1'b1;
      wait_bytes(FLEN, 40, ok);
      n_checks++; if (!ok) $display("FAIL bp_resume: got %0d bytes want %0d", captured.size(), FLEN); else n_pass++;
      n_checks++;
      if (captured.size() < 3 || captured[1] !== 8'h43 || captured[2] !== T0)
         $display("FAIL bp_rest: got %h %h want 43 %h", (captured.size() > 1) ? captured[1] : 8'hxx,
                  (captured.size() > 2) ? captured[2] : 8'hxx, T0);
      else n_pass++;
      wait_idle(20, ok);
   endtask

   task automatic test_overflow();
      bit ok;
      apply_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50);
         ir_cmd = 8'h10 + 8'(i);
         ir_cmd_ready = 1'b1;
      end
      @(negedge clk_50);
      ir_cmd_ready = 1'b0;
      n_checks++; if (fifo_level !== LW'(8)) $display("FAIL ovf_level: got %0d want 8", fifo_level); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      n_checks++; if (drop_count !== 8'd1) $display("FAIL ovf_drop_count: got %0d want 1", drop_count); else n_pass++;
      tx_ready = 1'b1;
      wait_bytes(9 * FLEN, 600, ok);
      n_checks++; if (!ok) $display("FAIL ovf_timeout: got %0d bytes want %0d", captured.size(), 9 * FLEN); else n_pass++;
      for (int f = 0; f < 9; f++) begin
         int bad;
         bad = -1;
         for (int k = 0; k < FLEN; k++)
            if (bad < 0 && (captured.size() <= f * FLEN + k || captured[f * FLEN + k] !== exp_char(8'h10 + 8'(f), k)))
               bad = k;
         n_checks++;
         if (bad >= 0)
            $display("FAIL ovf_frame%0d: char %0d got %h want %h", f, bad,
                     (captured.size() > f * FLEN + bad) ? captured[f * FLEN + bad] : 8'hxx, exp_char(8'h10 + 8'(f), bad));
         else n_pass++;
      end
      wait_idle(30, ok);
      n_checks++; if (captured.size() != 9 * FLEN) $display("FAIL ovf_total: got %0d bytes want %0d", captured.size(), 9 * FLEN); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
   endtask

   task automatic test_drop_saturation();
      apply_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 309; i++) begin
         @(negedge clk_50);
         if (i == 263) begin
            n_checks++; if (drop_count !== 8'd254) $display("FAIL sat_pre: got %0d want 254", drop_count); else n_pass++;
         end
         ir_cmd = 8'(i);
         ir_cmd_ready = 1'b1;
      end
      @(negedge clk_50);
      ir_cmd_ready = 1'b0;
      n_checks++; if (drop_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", drop_count); else n_pass++;
      n_checks++; if (fifo_level !== LW'(8)) $display("FAIL sat_level: got %0d want 8", fifo_level); else n_pass++;
      apply_reset();
      n_checks++; if (drop_count !== 8'd0 || overflow !== 1'b0)
         $display("FAIL sat_cleared: got %0d/%b want 0/0", drop_count, overflow);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      captured.delete();
      tx_ready = 1'b1;
      strobe(8'hA7);
      wait_bytes(2, 40, ok);
      n_checks++; if (!ok) $display("FAIL mid_two_chars: got %0d bytes want 2", captured.size()); else n_pass++;
      #1;
      reset = 1'b0;
      #1;
      n_checks++; if (tx_load !== 1'b0) $display("FAIL mid_tx_load: got %b want 0", tx_load); else n_pass++;
      n_checks++; if (tx_data !== 8'h00) $display("FAIL mid_tx_data: got %h want 00", tx_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (fifo_level !== '0) $display("FAIL mid_level: got %0d want 0", fifo_level); else n_pass++;
      @(negedge clk_50);
      reset = 1'b1;
      repeat (30) @(negedge clk_50);
      n_checks++; if (captured.size() != 2) $display("FAIL mid_no_more: got %0d bytes want 2", captured.size()); else n_pass++;
      strobe(8'h42);
      wait_bytes(2 + FLEN, 60, ok);
      n_checks++;
      if (!ok || captured[2] !== 8'h34 || captured[3] !== 8'h32)
         $display("FAIL mid_new_frame: got %0d bytes want 34 32 after restart", captured.size());
      else n_pass++;
      wait_idle(20, ok);
   endtask

   initial begin
      test_reset();
      test_single();
      test_nibble_edges();
      test_backpressure();
      test_overflow();
      test_drop_saturation();
      test_reset_mid_frame();
      n_checks++; if (dbl_load != 0) $display("FAIL load_width: got %0d multi-cycle loads want 0", dbl_load); else n_pass++;
      n_checks++; if (load_nobusy != 0) $display("FAIL load_busy: got %0d loads without busy want 0", load_nobusy); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ir_cmd_uart_bridge.md
IR_CMD_UART_BRIDGE -- requirements
Module: ir_cmd_uart_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command buffer entries (power of 2, 2..32).
REQ-002 SHALL have port clk_50  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ir_cmd  input  8  decoded IR command byte from the IR receiver.
REQ-005 SHALL have port ir_cmd_ready  input  1  one-cycle strobe, ir_cmd valid in that cycle.
REQ-006 SHALL have port tx_ready  input  1  UART transmitter able to accept a byte.
REQ-007 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-008 SHALL have port tx_load  output  1  one-cycle load strobe to UART transmitter.
REQ-009 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  commands currently buffered.
REQ-010 SHALL have port overflow  output  1  sticky: at least one command dropped.
REQ-011 SHALL have port drop_count  output  8  dropped commands, saturating.
REQ-012 SHALL have port busy  output  1  high while a frame is in transmission.

Function
REQ-013 SHALL push ir_cmd into the FIFO on each clock where ir_cmd_ready=1 and FIFO not full.
REQ-014 SHALL, when ir_cmd_ready=1 and FIFO full (level sampled before any same-cycle pop), drop the byte, set overflow, increment drop_count unless at 255.
REQ-015 SHALL allow simultaneous push and pop when not full; level unchanged.
REQ-016 SHALL transmit each command as a frame: upper-nibble ASCII hex, lower-nibble ASCII hex, then terminator (REQ-027/028).
REQ-017 SHALL encode nibbles 0-9 as 0x30-0x39 and A-F as uppercase 0x41-0x46.
REQ-018 SHALL implement FSM states IDLE, POP, SEND, GAP; frame character index 0..3 held in a counter.
REQ-019 SHALL go IDLE->POP when FIFO non-empty; POP latches head byte, pops it, -> SEND (index 0).
REQ-020 SHALL in SEND, when tx_ready=1, drive tx_data with current character and tx_load=1 for exactly one cycle, -> GAP.
REQ-021 SHALL in GAP ignore tx_ready for one cycle, then -> SEND with index+1, or -> IDLE after last character.
REQ-022 SHALL hold tx_data stable from the tx_load cycle until the next tx_load.
REQ-023 SHALL assert busy in POP, SEND, GAP; low in IDLE.
REQ-024 SHALL never abort a frame once POP executed; further commands wait in FIFO.
REQ-025 SHALL give first tx_load no earlier than 2 cycles after the push strobe (push, POP, SEND).

Reset
REQ-026 SHALL on reset=0 asynchronously clear FIFO pointers, fifo_level=0, overflow=0, drop_count=0, tx_load=0, tx_data=0x00, busy=0, FSM=IDLE; a frame in progress is discarded.

Configuration
REQ-027 SHALL, with macro IR_BRIDGE_CRLF_EN defined, terminate each frame with 0x0D then 0x0A (4 characters).
REQ-028 SHALL, without IR_BRIDGE_CRLF_EN, terminate each frame with single 0x20 (3 characters).

Structure
REQ-029 SHALL place FSM state encodings, ASCII constants (0x30, 0x41, 0x0D, 0x0A, 0x20) and frame length in a shared include/package ir_bridge_pkg.
REQ-030 SHALL implement the buffer as sub-module ir_cmd_fifo (sync FIFO, registered level, full/empty flags).

Verification
REQ-031 SHALL test single command: ir_cmd=0x5A strobe, tx_ready=1 -> tx_data sequence 0x35,0x41,0x0D,0x0A (CRLF_EN), each with one-cycle tx_load, busy high throughout.
REQ-032 SHALL test nibble edges: 0x09 -> 0x30,0x39; 0xF0 -> 0x46,0x30; without CRLF_EN terminator 0x20 only.
REQ-033 SHALL test backpressure: tx_ready=0 for 20 cycles after first char -> no tx_load, tx_data held, resumes when tx_ready=1.
REQ-034 SHALL test overflow: 10 strobes back-to-back, tx_ready=0, FIFO_DEPTH=8 -> fifo_level 7 (one popped into frame) or 8 as modelled, overflow=1, drop_count=1-2 matching model; frames for accepted bytes emitted in order.
REQ-035 SHALL test drop_count saturation: 300 drops -> drop_count=255.
REQ-036 SHALL test reset mid-frame: reset=0 after second character -> all outputs to reset values immediately, no further tx_load until a new strobe.
